seq_controller: RTL and testbench
=================================

SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter PC_LIMIT, default 64'h519, meaning the highest legal fetch address; PC above it flags an address error.
REQ-003 clk  input  1  the single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins execution from IDLE.
REQ-006 step  input  1  single-step advance pulse; used only when SEQ_CTRL_STEP_EN is defined.
REQ-007 icode  input  4  fetched instruction code.
REQ-008 instr_valid  input  1  fetch reports a legal icode.
REQ-009 imem_error  input  1  fetch reports an instruction-memory fault.
REQ-010 dmem_error  input  1  memory stage reports a data-memory fault.
REQ-011 pc_next  input  64  new PC from the PC-select logic.
REQ-012 PC  output  64  current program counter driven to fetch.
REQ-013 fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en  output  1 each  stage strobes; at most one high per cycle.
REQ-014 status  output  2  00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-015 halted  output  1  high while in HALT.
REQ-016 instr_count  output  32  number of retired instructions.

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; each active state lasts exactly one cycle.
REQ-018 Each stage strobe SHALL be high only in its state; all strobes low in IDLE and HALT.
REQ-019 IDLE -> FETCH on start=1; start in any other state SHALL be ignored.
REQ-020 FETCH: imem_error=1 or PC>PC_LIMIT -> HALT, status ADR; else instr_valid=0 -> HALT, status INS; else -> DECODE. ADR has priority over INS.
REQ-021 DECODE -> EXECUTE -> MEMORY unconditionally.
REQ-022 MEMORY: dmem_error=1 -> HALT, status ADR, WRITEBACK and PCUPD skipped; else -> WRITEBACK.
REQ-023 WRITEBACK -> PCUPD unconditionally.
REQ-024 PCUPD: PC <= pc_next, instr_count increments; icode=4'h0 -> HALT, status HLT; else -> FETCH.
REQ-025 One instruction SHALL take 6 cycles from FETCH entry to next FETCH entry.
REQ-026 instr_count SHALL saturate at 32'hFFFF_FFFF.
REQ-027 On error halts PC SHALL keep the faulting instruction's address; instr_count SHALL NOT increment.
REQ-028 HALT SHALL be terminal until rst_n asserted; start and step ignored.
REQ-029 icode and instr_valid SHALL be sampled only in FETCH; later changes have no effect on status.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, PC=RESET_PC, status=AOK, halted=0, instr_count=0, all strobes 0, regardless of current state.
REQ-031 Release of rst_n SHALL leave the block in IDLE awaiting start.

Configuration
REQ-032 Macro SEQ_CTRL_STEP_EN defined: PCUPD with non-halt icode -> IDLE-like wait; next FETCH only on step=1 (start also accepted).
REQ-033 SEQ_CTRL_STEP_EN undefined: step port SHALL be ignored; PCUPD -> FETCH directly.

Verification
REQ-034 Reset, start, icode=3 valid, pc_next=10 -> strobes fetch..pcupd on cycles 1..6, PC=10, instr_count=1, FETCH on cycle 7.
REQ-035 icode=0 valid, pc_next=1 -> after PCUPD status=01, halted=1, PC=1, instr_count=1; start afterwards no effect.
REQ-036 instr_valid=0 at PC=0x20 -> next cycle status=11, halted=1, PC=0x20, instr_count unchanged, no decode_en.
REQ-037 imem_error=1 and instr_valid=0 in same FETCH -> status=10 (ADR priority); dmem_error=1 in MEMORY -> status=10, writeback_en never asserted.
REQ-038 rst_n low mid-EXECUTE -> same-cycle strobes 0, PC=RESET_PC, status=00, instr_count=0.
REQ-039 With SEQ_CTRL_STEP_EN: after one instruction block waits with strobes low for 5 cycles; step pulse -> fetch_en next cycle.

Source files
------------

// File: rtl/seq_controller_if.sv
// rtl/seq_controller_if.sv - Control/status bundle between the sequencer and its datapath
//
// Purpose: groups every non-clock signal of seq_controller into one bundle.
// The slave modport is the controller's view; the master modport is the view
// of whoever drives the fetch/memory feedback and observes the strobes.
//
// Signals (direction seen from the controller):
//   start        in   1   begin execution from IDLE
//   step         in   1   single-step advance (SEQ_CTRL_STEP_EN builds only)
//   icode        in   4   fetched instruction code
//   instr_valid  in   1   fetch reports a legal icode
//   imem_error   in   1   instruction-memory fault
//   dmem_error   in   1   data-memory fault
//   pc_next      in   64  next PC from PC-select logic
//   PC           out  64  current program counter
//   *_en         out  1   stage strobes, at most one high per cycle
//   status       out  2   00 AOK, 01 HLT, 10 ADR, 11 INS
//   halted       out  1   high while in HALT
//   instr_count  out  32  retired instruction count (saturating)
interface seq_controller_if;
  logic        start;
  logic        step;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic        dmem_error;
  logic [63:0] pc_next;
  logic [63:0] PC;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        memory_en;
  logic        writeback_en;
  logic        pcupd_en;
  logic [1:0]  status;
  logic        halted;
  logic [31:0] instr_count;

  modport master (
    output start, step, icode, instr_valid, imem_error, dmem_error, pc_next,
    input  PC, fetch_en, decode_en, execute_en, memory_en, writeback_en,
           pcupd_en, status, halted, instr_count
  );

  modport slave (
    input  start, step, icode, instr_valid, imem_error, dmem_error, pc_next,
    output PC, fetch_en, decode_en, execute_en, memory_en, writeback_en,
           pcupd_en, status, halted, instr_count
  );
endinterface

// File: rtl/seq_controller.sv
// rtl/seq_controller.sv - Six-stage instruction sequencer with fault/halt status
//
// Purpose: steps one instruction at a time through FETCH, DECODE, EXECUTE,
// MEMORY, WRITEBACK and PCUPD (one cycle each), raising the matching stage
// strobe, and stops in a terminal HALT on a halt instruction or a fault.
//
// Ports:
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low reset
//   bus    seq_controller_if.slave  (see rtl/seq_controller_if.sv)
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   PC_LIMIT  highest legal fetch address
//
// Optional feature macro: SEQ_CTRL_STEP_EN -- after each retired non-halt
// instruction wait in IDLE until step (or start) before the next fetch.
module seq_controller #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_LIMIT = 64'h519
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_controller_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;

  localparam logic [1:0] ST_AOK = 2'b00;
  localparam logic [1:0] ST_HLT = 2'b01;
  localparam logic [1:0] ST_ADR = 2'b10;
  localparam logic [1:0] ST_INS = 2'b11;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] count_q, count_d;
  logic [3:0]  icode_q, icode_d;
  logic        halted_q, halted_d;
  logic [5:0]  strobe_q, strobe_d;   // {pcupd, writeback, memory, execute, decode, fetch}

  logic        advance;

`ifdef SEQ_CTRL_STEP_EN
  assign advance = bus.start | bus.step;
`else
  logic unused_step;
  assign unused_step = bus.step;
  assign advance     = bus.start;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    status_d = status_q;
    count_d  = count_q;
    icode_d  = icode_q;
    case (state_q)
      S_IDLE: begin
        if (advance) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_error || (pc_q > PC_LIMIT)) begin
          state_d  = S_HALT;
          status_d = ST_ADR;
        end else if (!bus.instr_valid) begin
          state_d  = S_HALT;
          status_d = ST_INS;
        end else begin
          state_d = S_DECODE;
          // Latched here so PCUPD ignores any later icode change.
          icode_d = bus.icode;
        end
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_MEMORY;
      S_MEMORY: begin
        if (bus.dmem_error) begin
          state_d  = S_HALT;
          status_d = ST_ADR;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d    = bus.pc_next;
        count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
        if (icode_q == 4'h0) begin
          state_d  = S_HALT;
          status_d = ST_HLT;
        end else begin
`ifdef SEQ_CTRL_STEP_EN
          state_d = S_IDLE;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    halted_d = (state_d == S_HALT);
    strobe_d = {state_d == S_PCUPD,  state_d == S_WRITEBACK, state_d == S_MEMORY,
                state_d == S_EXECUTE, state_d == S_DECODE,   state_d == S_FETCH};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      status_q <= ST_AOK;
      count_q  <= 32'd0;
      icode_q  <= 4'h0;
      halted_q <= 1'b0;
      strobe_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      status_q <= status_d;
      count_q  <= count_d;
      icode_q  <= icode_d;
      halted_q <= halted_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.PC           = pc_q;
  assign bus.status       = status_q;
  assign bus.instr_count  = count_q;
  assign bus.halted       = halted_q;
  assign bus.fetch_en     = strobe_q[0];
  assign bus.decode_en    = strobe_q[1];
  assign bus.execute_en   = strobe_q[2];
  assign bus.memory_en    = strobe_q[3];
  assign bus.writeback_en = strobe_q[4];
  assign bus.pcupd_en     = strobe_q[5];

endmodule

// File: tb/tb_seq_controller.sv
// tb/tb_seq_controller.sv - Directed, table-driven bench for seq_controller
module tb_seq_controller;

  logic clk;
  logic rst_n;

  seq_controller_if bus ();

  seq_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_fetch, n_decode, n_wb;

  typedef struct {
    logic [63:0] pre_pc;     // 0: no warm-up; else retire one icode=1 instr to reach this PC first
    logic [3:0]  icode;
    logic        valid;
    logic        imem_err;
    logic        dmem_err;
    logic [63:0] pc_next;
    logic [1:0]  exp_status;
    logic        exp_halted;
    logic [63:0] exp_pc;
    logic [31:0] exp_count;
    int          exp_fetch;  // fetch strobes seen in 7 cycles from FETCH entry
    int          exp_decode;
    int          exp_wb;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {bus.pcupd_en, bus.writeback_en, bus.memory_en,
            bus.execute_en, bus.decode_en, bus.fetch_en};
  endfunction

  function automatic int stage_code(input logic [5:0] s);
    int code;
    code = 0;
    for (int k = 0; k < 6; k++) if (s[k]) code = k + 1;
    return code;
  endfunction

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.step        = 1'b0;
    bus.icode       = 4'h1;
    bus.instr_valid = 1'b1;
    bus.imem_error  = 1'b0;
    bus.dmem_error  = 1'b0;
    bus.pc_next     = 64'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Sample the current cycle at the negedge, then move to the next one.
  task automatic observe(input int n);
    logic [5:0] s;
    for (int i = 0; i < n; i++) begin
      s = strobes();
      check("onehot_strobes", 64'($countones(s) <= 1), 64'd1);
      if (s[0]) n_fetch++;
      if (s[1]) n_decode++;
      if (s[4]) n_wb++;
      @(negedge clk);
    end
  endtask

  // Bring the next FETCH on after a retired instruction (step builds wait in IDLE).
  task automatic resume_fetch();
`ifdef SEQ_CTRL_STEP_EN
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
`endif
  endtask

  task automatic warm_up(input logic [63:0] target);
    bus.icode       = 4'h1;
    bus.instr_valid = 1'b1;
    bus.pc_next     = target;
    pulse_start();
    observe(6);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_f;
    logic [5:0] s;

    //            pre     ic    v  imem dmem pc_next  st     h  pc       cnt fetch dec wb
    vecs[0] = '{64'h0,   4'h3, 1, 0, 0, 64'd10,  2'b00, 0, 64'd10,  1, 2, 1, 1};
    vecs[1] = '{64'h0,   4'h0, 1, 0, 0, 64'd1,   2'b01, 1, 64'd1,   1, 1, 1, 1};
    vecs[2] = '{64'h20,  4'h3, 0, 0, 0, 64'd7,   2'b11, 1, 64'h20,  1, 1, 0, 0};
    vecs[3] = '{64'h0,   4'h3, 0, 1, 0, 64'd7,   2'b10, 1, 64'h0,   0, 1, 0, 0};
    vecs[4] = '{64'h0,   4'h3, 1, 0, 1, 64'd10,  2'b10, 1, 64'h0,   0, 1, 1, 0};
    vecs[5] = '{64'h600, 4'h3, 1, 0, 0, 64'd7,   2'b10, 1, 64'h600, 1, 1, 0, 0};
    vecs[6] = '{64'h519, 4'h3, 1, 0, 0, 64'h40,  2'b00, 0, 64'h40,  2, 2, 1, 1};
    vecs[7] = '{64'h0,   4'h3, 0, 0, 0, 64'd7,   2'b11, 1, 64'h0,   0, 1, 0, 0};

    // Reset values, sampled both during and after reset.
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_pc",      bus.PC, 64'h0);
    check("rst_status",  64'(bus.status), 64'd0);
    check("rst_halted",  64'(bus.halted), 64'd0);
    check("rst_count",   64'(bus.instr_count), 64'd0);
    check("rst_strobes", 64'(strobes()), 64'd0);
    do_reset();
    @(negedge clk);
    check("idle_no_strobes", 64'(strobes()), 64'd0);

    // Table-driven single-instruction scenarios.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      if (vecs[v].pre_pc != 64'h0) warm_up(vecs[v].pre_pc);
      bus.icode       = vecs[v].icode;
      bus.instr_valid = vecs[v].valid;
      bus.imem_error  = vecs[v].imem_err;
      bus.dmem_error  = vecs[v].dmem_err;
      bus.pc_next     = vecs[v].pc_next;
      if (vecs[v].pre_pc != 64'h0) resume_fetch();
      else pulse_start();
      n_fetch = 0; n_decode = 0; n_wb = 0;
      observe(7);
      exp_f = vecs[v].exp_fetch;
`ifdef SEQ_CTRL_STEP_EN
      if (!vecs[v].exp_halted) exp_f = exp_f - 1;
`endif
      check($sformatf("v%0d_status", v), 64'(bus.status),      64'(vecs[v].exp_status));
      check($sformatf("v%0d_halted", v), 64'(bus.halted),      64'(vecs[v].exp_halted));
      check($sformatf("v%0d_pc", v),     bus.PC,               vecs[v].exp_pc);
      check($sformatf("v%0d_count", v),  64'(bus.instr_count), 64'(vecs[v].exp_count));
      check($sformatf("v%0d_fetch", v),  64'(n_fetch),         64'(exp_f));
      check($sformatf("v%0d_decode", v), 64'(n_decode),        64'(vecs[v].exp_decode));
      check($sformatf("v%0d_wb", v),     64'(n_wb),            64'(vecs[v].exp_wb));
    end

    // Stage order: fetch..pcupd on cycles 1..6, then next FETCH on cycle 7.
    do_reset();
    bus.icode = 4'h3; bus.pc_next = 64'd10;
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("order_cycle%0d", c), 64'(stage_code(strobes())), 64'(c));
      @(negedge clk);
    end
`ifdef SEQ_CTRL_STEP_EN
    check("order_cycle7", 64'(stage_code(strobes())), 64'd0);
`else
    check("order_cycle7", 64'(stage_code(strobes())), 64'd1);
`endif
    check("order_pc", bus.PC, 64'd10);

    // icode/instr_valid changing after FETCH must not affect the outcome.
    do_reset();
    bus.icode = 4'h0; bus.instr_valid = 1'b1; bus.pc_next = 64'd5;
    pulse_start();
    observe(1);
    bus.icode = 4'h3; bus.instr_valid = 1'b0;
    observe(5);
    check("late_icode_status", 64'(bus.status), 64'd1);
    check("late_icode_halted", 64'(bus.halted), 64'd1);
    check("late_icode_pc",     bus.PC, 64'd5);

    // HALT is terminal: start and step are ignored.
    bus.start = 1'b1; bus.step = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.step = 1'b0;
    n_fetch = 0;
    observe(3);
    check("halt_no_fetch",     64'(n_fetch), 64'd0);
    check("halt_strobes",      64'(strobes()), 64'd0);
    check("halt_status_kept",  64'(bus.status), 64'd1);
    check("halt_count_kept",   64'(bus.instr_count), 64'd1);

    // Asynchronous reset in the middle of EXECUTE of the second instruction.
    do_reset();
    warm_up(64'h30);
    bus.icode = 4'h3; bus.pc_next = 64'h38;
    resume_fetch();
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_execute", 64'(bus.execute_en), 64'd1);
    check("pre_rst_pc",      bus.PC, 64'h30);
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", 64'(strobes()), 64'd0);
    check("midrst_pc",      bus.PC, 64'h0);
    check("midrst_count",   64'(bus.instr_count), 64'd0);
    check("midrst_status",  64'(bus.status), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(strobes()), 64'd0);
    pulse_start();
    check("post_rst_start", 64'(bus.fetch_en), 64'd1);

`ifdef SEQ_CTRL_STEP_EN
    // Step mode: wait with strobes low, then fetch one cycle after step.
    do_reset();
    bus.icode = 4'h3; bus.pc_next = 64'd8;
    pulse_start();
    observe(6);
    for (int c = 0; c < 5; c++) begin
      s = strobes();
      check($sformatf("step_wait%0d", c), 64'(s), 64'd0);
      @(negedge clk);
    end
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    check("step_fetch", 64'(bus.fetch_en), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
